// File: rtl/pakesson_glitcher_if.sv
// Host-side pin bundle of the glitcher: TinyTapeout-style user I/O.
interface pakesson_glitcher_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/pakesson_glitcher.sv
// Fault-injection pulse generator: on a trigger edge, waits DELAY clocks then emits
// PULSES glitch pulses of WIDTH clocks separated by WIDTH-clock gaps.
module pakesson_glitcher #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  pakesson_glitcher_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_PULSE = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0][6:0] ctl_sync;
  logic [SYNC_STAGES-1:0][7:0] dat_sync;
  logic [2:0]  prev;
  logic [6:0]  ctl;
  logic [7:0]  dat;
  logic [15:0] delay_reg;
  logic [7:0]  width_reg;
  logic [7:0]  pulses_reg;
  logic [15:0] cnt;
  logic [7:0]  rem;
  logic [15:0] width_m1;
  logic [7:0]  pulses_m1;
  logic [7:0]  uo;
  logic        trig_edge;
  logic        arm_edge;
  logic        wr_edge;
  logic        disarm;
  logic        busy;
  logic [1:0]  addr;
  logic        unused_ok;
  state_t      state;

  // uo_out image for a given state: {code, done, busy, armed, glitch_n, glitch}
  function automatic logic [7:0] outs(state_t s);
    logic g;
    g = (s == S_PULSE);
    return {3'(s), s == S_DONE, (s == S_DELAY) || (s == S_PULSE) || (s == S_GAP),
            s == S_ARMED, ~g, g};
  endfunction

  assign ctl       = ctl_sync[SYNC_STAGES-1];
  assign dat       = dat_sync[SYNC_STAGES-1];
  assign trig_edge = ctl[5] ? (~ctl[0] & prev[0]) : (ctl[0] & ~prev[0]);
  assign arm_edge  = ctl[1] & ~prev[1];
  assign wr_edge   = ctl[2] & ~prev[2];
  assign addr      = ctl[4:3];
  assign disarm    = ctl[6];
  assign busy      = (state == S_DELAY) || (state == S_PULSE) || (state == S_GAP);
  // Zero-valued WIDTH/PULSES behave as 1
  assign width_m1  = (width_reg == 8'd0) ? 16'd0 : 16'(width_reg) - 16'd1;
  assign pulses_m1 = (pulses_reg == 8'd0) ? 8'd0 : pulses_reg - 8'd1;

  assign bus.uo_out  = uo;
  assign bus.uio_out = 8'd0;
  assign bus.uio_oe  = 8'd0;
  assign unused_ok   = &{1'b0, bus.ena, bus.ui_in[7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_sync   <= '0;
      dat_sync   <= '0;
      prev       <= 3'd0;
      delay_reg  <= 16'd0;
      width_reg  <= 8'd0;
      pulses_reg <= 8'd0;
      cnt        <= 16'd0;
      rem        <= 8'd0;
      state      <= S_IDLE;
      uo         <= outs(S_IDLE);
    end else begin
      ctl_sync <= {ctl_sync[SYNC_STAGES-2:0], bus.ui_in[6:0]};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.uio_in};
      prev     <= ctl[2:0];

      if (disarm) begin
        state <= S_IDLE;
        uo    <= outs(S_IDLE);
      end else begin
        if (wr_edge && !busy) begin
          unique case (addr)
            2'd0: delay_reg[7:0]  <= dat;
            2'd1: delay_reg[15:8] <= dat;
            2'd2: width_reg       <= dat;
            2'd3: pulses_reg      <= dat;
          endcase
        end

        case (state)
          S_IDLE, S_DONE: begin
            if (arm_edge) begin
              state <= S_ARMED;
              uo    <= outs(S_ARMED);
            end
          end
          S_ARMED: begin
            if (trig_edge) begin
              if (delay_reg == 16'd0) begin
                state <= S_PULSE;
                uo    <= outs(S_PULSE);
                cnt   <= width_m1;
                rem   <= pulses_m1;
              end else begin
                state <= S_DELAY;
                uo    <= outs(S_DELAY);
                cnt   <= delay_reg - 16'd1;
              end
            end
          end
          S_DELAY: begin
            if (cnt == 16'd0) begin
              state <= S_PULSE;
              uo    <= outs(S_PULSE);
              cnt   <= width_m1;
              rem   <= pulses_m1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          S_PULSE: begin
            if (cnt != 16'd0) begin
              cnt <= cnt - 16'd1;
            end else if (rem == 8'd0) begin
              state <= S_DONE;
              uo    <= outs(S_DONE);
            end else begin
              state <= S_GAP;
              uo    <= outs(S_GAP);
              cnt   <= width_m1;
              rem   <= rem - 8'd1;
            end
          end
          S_GAP: begin
            if (cnt == 16'd0) begin
              state <= S_PULSE;
              uo    <= outs(S_PULSE);
              cnt   <= width_m1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          default: begin
            state <= S_IDLE;
            uo    <= outs(S_IDLE);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pakesson_glitcher.sv
// Directed plus randomized checks of the glitcher against a cycle-count timing model.
module tb_pakesson_glitcher;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  pakesson_glitcher_if bus ();

  pakesson_glitcher dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected uo_out for a state code: {code, done, busy, armed, glitch_n, glitch}
  function automatic logic [7:0] exp_uo(input int code);
    logic [2:0] c;
    logic       g;
    c = 3'(code);
    g = (code == 3);
    return {c, code == 5, (code >= 2) && (code <= 4), code == 1, ~g, g};
  endfunction

  // State code n clocks after the trigger pin changes, from the timing rules
  function automatic int model_code(input int n, input int d, input int w, input int p);
    int we, pe, t;
    we = (w == 0) ? 1 : w;
    pe = (p == 0) ? 1 : p;
    if (n < 3) return 1;
    if (n < 3 + d) return 2;
    t = n - 3 - d;
    if (t < (2 * pe - 1) * we) return ((t / we) % 2 == 0) ? 3 : 4;
    return 5;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    bus.ui_in[4:3] = a;
    bus.uio_in     = d;
    tick();
    bus.ui_in[2] = 1'b1;
    tick(4);
    bus.ui_in[2] = 1'b0;
    tick(2);
  endtask

  task automatic configure(input int d, input int w, input int p);
    write_reg(2'd0, 8'(d));
    write_reg(2'd1, 8'(d >> 8));
    write_reg(2'd2, 8'(w));
    write_reg(2'd3, 8'(p));
  endtask

  task automatic arm();
    bus.ui_in[1] = 1'b1;
    tick(4);
    bus.ui_in[1] = 1'b0;
    tick(4);
  endtask

  task automatic disarm();
    bus.ui_in[6] = 1'b1;
    tick(4);
    bus.ui_in[6] = 1'b0;
    tick(4);
  endtask

  // Arm, fire the trigger with the given polarity and check every cycle of the shot
  task automatic fire(input string tag, input int d, input int w, input int p, input bit pol);
    int we, pe, total;
    we = (w == 0) ? 1 : w;
    pe = (p == 0) ? 1 : p;
    total = 3 + d + (2 * pe - 1) * we + 2;
    bus.ui_in[5] = pol;
    bus.ui_in[0] = 1'b0;
    tick(4);
    arm();
    check({tag, "_armed"}, bus.uo_out, exp_uo(1));
    if (pol) begin
      bus.ui_in[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
        tick();
        check({tag, "_rise_ignored"}, bus.uo_out, exp_uo(1));
      end
      bus.ui_in[0] = 1'b0;
    end else begin
      bus.ui_in[0] = 1'b1;
    end
    for (int n = 1; n <= total; n++) begin
      tick();
      check($sformatf("%s_clk%0d", tag, n), bus.uo_out, exp_uo(model_code(n, d, w, p)));
    end
    bus.ui_in[0] = 1'b0;
    tick(4);
  endtask

  initial begin
    int d, w, p;
    bit pol;
    n_assert = 0;
    n_fail   = 0;
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'd0;
    bus.uio_in = 8'd0;
    tick(3);
    check("reset_uo", bus.uo_out, 8'h02);
    check("reset_uio_oe", bus.uio_oe, 8'h00);
    check("reset_uio_out", bus.uio_out, 8'h00);
    rst_n = 1'b1;
    tick(2);

    write_reg(2'd2, 8'd5);
    tick(2);
    check("write_idle_stays_idle", bus.uo_out, 8'h02);

    configure(10, 4, 1);
    fire("d10w4p1", 10, 4, 1, 1'b0);

    configure(0, 2, 3);
    fire("d0w2p3", 0, 2, 3, 1'b0);

    configure(5, 3, 2);
    fire("pol_fall", 5, 3, 2, 1'b1);

    // Disarm in a long DELAY; a write while busy must not land
    configure(1000, 3, 1);
    bus.ui_in[5] = 1'b0;
    arm();
    bus.ui_in[0] = 1'b1;
    tick(20);
    check("long_delay_busy", bus.uo_out, exp_uo(2));
    write_reg(2'd2, 8'd9);
    check("delay_after_write", bus.uo_out, exp_uo(2));
    bus.ui_in[6] = 1'b1;
    tick(2);
    check("disarm_sync_pending", bus.uo_out, exp_uo(2));
    tick();
    check("disarm_idle", bus.uo_out, exp_uo(0));
    bus.ui_in[6] = 1'b0;
    bus.ui_in[0] = 1'b0;
    tick(4);
    check("disarm_stays_idle", bus.uo_out, exp_uo(0));
    write_reg(2'd0, 8'd0);
    write_reg(2'd1, 8'd0);
    fire("busy_write_ignored", 0, 3, 1, 1'b0);

    // Zero WIDTH/PULSES, trigger while DONE, re-arm clears done
    configure(2, 0, 0);
    fire("w0p0", 2, 0, 0, 1'b0);
    bus.ui_in[0] = 1'b1;
    tick(6);
    check("trig_in_done", bus.uo_out, exp_uo(5));
    bus.ui_in[0] = 1'b0;
    tick(4);
    arm();
    check("rearm_clears_done", bus.uo_out, exp_uo(1));
    disarm();
    check("disarm_from_armed", bus.uo_out, exp_uo(0));

    for (int k = 0; k < 6; k++) begin
      d   = int'($urandom_range(0, 30));
      w   = int'($urandom_range(0, 5));
      p   = int'($urandom_range(0, 4));
      pol = 1'($urandom_range(0, 1));
      configure(d, w, p);
      fire($sformatf("rand%0d", k), d, w, p, pol);
    end

    // Reset mid-pulse drops glitch at once and loses config
    configure(0, 8, 1);
    bus.ui_in[5] = 1'b0;
    arm();
    bus.ui_in[0] = 1'b1;
    tick(5);
    check("mid_pulse_high", bus.uo_out, exp_uo(3));
    rst_n = 1'b0;
    #1;
    check("async_reset_glitch_low", bus.uo_out, 8'h02);
    tick();
    rst_n = 1'b1;
    bus.ui_in[0] = 1'b0;
    tick(4);
    fire("after_reset_defaults", 0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
